// File: rtl/mxint_quantizer.sv
// FP16 -> MXINT8 block quantizer: 32 elements per block sharing one latched exponent.
// Define MXQ_ROUND_EN for round-half-up magnitudes; the default build truncates toward zero.
module mxint_quantizer (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [4:0]  shared_exp,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] fp16_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  mx_out,
    output logic [4:0]  out_idx,
    output logic [4:0]  exp_out,
    output logic        busy,
    output logic        block_done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CONV  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0] state;
    logic [4:0] cnt;
    logic       accept;
    logic       out_fire;

    // Element conversion datapath
    logic        sgn;
    logic [4:0]  e;
    logic [4:0]  ee;
    logic [10:0] sig;
    logic        sat;
    logic [4:0]  d;
    logic [5:0]  sh;
    logic [6:0]  mag_trunc;
    logic [6:0]  mag;
    logic [7:0]  q_val;
`ifdef MXQ_ROUND_EN
    logic        rbit;
    logic [7:0]  mag_sum;
`endif

    always_comb begin
        sgn = fp16_in[15];
        e   = fp16_in[14:10];
        if (e != 5'd0) begin
            sig = {1'b1, fp16_in[9:0]};
            ee  = e;
        end else begin
            sig = {1'b0, fp16_in[9:0]};
            ee  = 5'd1;
        end
        // An element larger than the block maximum is an upstream error: clamp to full scale.
        sat       = (ee > exp_out);
        d         = sat ? 5'd0 : (exp_out - ee);
        sh        = 6'd4 + {1'b0, d};
        mag_trunc = (sh >= 6'd11) ? 7'd0 : 7'(sig >> sh);
`ifdef MXQ_ROUND_EN
        rbit    = (sh <= 6'd11) && ((sig & (11'd1 << (sh - 6'd1))) != 11'd0);
        mag_sum = {1'b0, mag_trunc} + {7'd0, rbit};
        mag     = mag_sum[7] ? 7'd127 : mag_sum[6:0];
`else
        mag     = mag_trunc;
`endif
        if (e == 5'd31 || sat) begin
            mag = 7'd127;
        end
        q_val = sgn ? (8'd0 - {1'b0, mag}) : {1'b0, mag};
    end

    assign in_ready   = (state == CONV) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign busy       = (state == CONV) || (state == DRAIN);
    assign block_done = (state == DRAIN) && out_fire;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            exp_out   <= 5'd0;
            out_valid <= 1'b0;
            mx_out    <= 8'd0;
            out_idx   <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_out <= shared_exp;
                        cnt     <= 5'd0;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    if (accept) begin
                        if (cnt == 5'd31) begin
                            state <= DRAIN;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                out_valid <= 1'b1;
                mx_out    <= q_val;
                out_idx   <= cnt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mxint_quantizer.md
MXINT_QUANTIZER -- requirements
Module: mxint_quantizer

Interface
REQ-001 SHALL have no parameters; block size fixed at 32 elements, element output width fixed at 8 bits.
REQ-002 SHALL have the following ports, one per line: name, direction, width, meaning.
  CLK  in  1  sole clock, rising edge.
  RST  in  1  reset, synchronous, active-high.
  start  in  1  one-cycle pulse (shared-exponent tree done); shared exponent valid on this cycle.
  shared_exp  in  5  block maximum FP16 exponent, sampled when start is accepted.
  in_valid  in  1  fp16_in is valid.
  in_ready  out  1  element accepted when in_valid and in_ready are both 1.
  fp16_in  in  16  FP16 element, in block order 0..31.
  out_valid  out  1  mx_out is valid.
  out_ready  in  1  downstream accepts when out_valid and out_ready are both 1.
  mx_out  out  8  two's-complement MXINT8 element.
  out_idx  out  5  index of the element on mx_out.
  exp_out  out  5  latched shared exponent, held until the next accepted start.
  busy  out  1  high in CONV and DRAIN.
  block_done  out  1  one-cycle pulse after element 31 is accepted downstream.

Function
REQ-003 SHALL implement FSM IDLE -> CONV -> DRAIN -> IDLE.
REQ-004 IDLE: start=1 SHALL latch shared_exp into exp_out, clear the element counter, go to CONV; start SHALL be ignored in CONV and DRAIN.
REQ-005 in_ready SHALL be 1 only in CONV and only when (out_valid==0 or out_ready==1); in IDLE and DRAIN it SHALL be 0.
REQ-006 Each accepted element SHALL appear on mx_out/out_idx with out_valid=1 exactly one cycle later (registered, latency 1); sustained throughput SHALL be 1 element/cycle.
REQ-007 While out_valid=1 and out_ready=0, mx_out, out_idx and out_valid SHALL hold.
REQ-008 Acceptance of element 31 SHALL move CONV -> DRAIN; DRAIN SHALL wait for the element-31 output handshake, then pulse block_done and return to IDLE in the same cycle.
REQ-009 Conversion: s=fp16_in[15], e=fp16_in[14:10], m=fp16_in[9:0]; sig={1,m} and ee=e if e!=0, else sig={0,m} and ee=1.
REQ-010 Define d=exp_out-ee; if ee>exp_out, set d=0 (upstream error) and saturate the magnitude.
REQ-011 Magnitude: sh=4+d; mag=sig>>sh (7-bit result); mag=0 if sh>=11.
REQ-012 e==31 (Inf/NaN) SHALL output mag=127 with sign preserved; NaN sign as given.
REQ-013 mx_out SHALL be -mag if s=1, else mag; mag=0 SHALL give 0x00 for either sign; range is -127..127, and -128 SHALL never be produced.
REQ-014 Counter SHALL not wrap mid-block; out_idx SHALL equal the accepted element's position 0..31.

Reset
REQ-015 With RST=1 at a clock edge: state=IDLE, out_valid=0, mx_out=0, out_idx=0, exp_out=0, busy=0, block_done=0, counter=0.
REQ-016 Reset mid-block SHALL discard all partial state; no block_done SHALL be issued for the aborted block.

Configuration
REQ-017 Macro MXQ_ROUND_EN defined: magnitude SHALL round half-up using the most significant shifted-out bit (only if sh<=11), then saturate to 127.
REQ-018 Macro MXQ_ROUND_EN undefined: truncation (round toward zero) per REQ-011, no rounding logic present.

Verification
REQ-019 start with shared_exp=15; elements 0x3C00, 0xBC00, 0x3E00, 0x3800 -> mx_out 0x40, 0xC0, 0x60, 0x20 with out_idx 0..3.
REQ-020 shared_exp=15; elements 0x0001 and 0x8000 -> 0x00 both; 0x7C00 -> 0x7F; 0xFC00 -> 0x81.
REQ-021 shared_exp=15; element 0x3C08 -> 0x41 with MXQ_ROUND_EN, 0x40 without; 0x3FFF -> 0x7F in both builds.
REQ-022 32 back-to-back elements with out_ready=1 -> 32 outputs on consecutive cycles, block_done on the cycle element 31 handshakes, busy low the cycle after.
REQ-023 out_ready=0 for 3 cycles mid-block -> in_ready=0 and mx_out/out_idx stable for those cycles, no element lost or duplicated; start pulsed in CONV is ignored (exp_out unchanged).
REQ-024 RST asserted after element 10 -> next cycle state IDLE, out_valid=0, no block_done; a new block after reset converts from out_idx 0.
